pow_nonce_gen: RTL and testbench

- Downstream consumer of the 27-trit LFSR random source in the PoW accelerator.
- Samples the 54-bit (27 trits, 2 bits per trit) random word over several cycles and packs NONCE_TRITS trits into a nonce field.
- Presents the nonce to the Curl hashing core with a valid/ready handshake.
- Keeps a running count of nonces issued.

---
 rtl/pow_nonce_gen.sv | 135 +++++++++++++
 tb/tb_pow_nonce_gen.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pow_nonce_gen.sv
// pow_nonce_gen
//   Packs NONCE_TRITS random trits into a nonce for the Curl hashing core.
//   The 54-bit (27-trit) LFSR word is captured once every STRIDE cycles.
//   After WORDS = NONCE_TRITS/27 captures, the nonce is offered with a
//   valid/ready handshake. A running count of handshakes is kept.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_rnd_trits  54-bit random word; trit k is bits [2k+1:2k]; 2'b10 is illegal
//   i_req        request a new nonce (sampled in IDLE and on the handshake edge)
//   i_ready      consumer ready
//   o_valid      nonce valid
//   o_nonce      packed nonce; word j is bits [54j+53:54j]
//   o_busy       high while filling
//   o_nonce_cnt  completed handshakes, wraps mod 2^32
//   o_err        sticky illegal-trit flag
//
// Build option
//   POW_NONCE_CHK_EN : when defined, each captured word is scanned for code
//                      2'b10 and o_err is set sticky. When undefined, no
//                      checking logic is built and o_err is tied low.

module pow_nonce_gen #(
    parameter int NONCE_TRITS = 81,
    parameter int STRIDE      = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [53:0]              i_rnd_trits,
    input  logic                     i_req,
    input  logic                     i_ready,
    output logic                     o_valid,
    output logic [2*NONCE_TRITS-1:0] o_nonce,
    output logic                     o_busy,
    output logic [31:0]              o_nonce_cnt,
    output logic                     o_err
);

    localparam int WORDS = NONCE_TRITS / 27;
    localparam int WCW   = (WORDS  > 1) ? $clog2(WORDS)  : 1;
    localparam int SCW   = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    typedef enum logic [1:0] {IDLE, FILL, VALID} state_t;

    state_t         state_q, state_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic [SCW-1:0] scnt_q, scnt_d;
    logic           cap;
    logic           last_cap;

    // A capture happens on the last cycle of each stride window.
    assign cap      = (state_q == FILL) && (scnt_q == SCW'(STRIDE - 1));
    assign last_cap = cap && (wcnt_q == WCW'(WORDS - 1));

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        scnt_d  = scnt_q;
        case (state_q)
            IDLE: begin
                if (i_req) begin
                    state_d = FILL;
                    wcnt_d  = '0;
                    scnt_d  = '0;
                end
            end
            FILL: begin
                if (cap) begin
                    scnt_d = '0;
                    wcnt_d = wcnt_q + 1'b1;
                    if (last_cap) state_d = VALID;
                end else begin
                    scnt_d = scnt_q + 1'b1;
                end
            end
            VALID: begin
                // i_req on the handshake edge chains straight into the next fill.
                if (i_ready) begin
                    if (i_req) begin
                        state_d = FILL;
                        wcnt_d  = '0;
                        scnt_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            scnt_q      <= '0;
            o_valid     <= 1'b0;
            o_busy      <= 1'b0;
            o_nonce     <= '0;
            o_nonce_cnt <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            scnt_q  <= scnt_d;
            o_valid <= (state_d == VALID);
            o_busy  <= (state_d == FILL);
            // o_valid is high exactly when state_q is VALID.
            if (o_valid && i_ready) o_nonce_cnt <= o_nonce_cnt + 32'd1;
            // Words not written in this fill keep their previous contents.
            for (int j = 0; j < WORDS; j++) begin
                if (cap && (wcnt_q == WCW'(j))) o_nonce[54*j +: 54] <= i_rnd_trits;
            end
        end
    end

`ifdef POW_NONCE_CHK_EN
    logic bad_code;

    always_comb begin
        bad_code = 1'b0;
        for (int k = 0; k < 27; k++) begin
            if (i_rnd_trits[2*k +: 2] == 2'b10) bad_code = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)                o_err <= 1'b0;
        else if (cap && bad_code) o_err <= 1'b1;
    end
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_pow_nonce_gen.sv
module tb_pow_nonce_gen;

    localparam int NT = 81;
    localparam int W  = NT / 27;
    localparam int NW = 2 * NT;
`ifdef POW_NONCE_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic          req4 = 1'b0;
    logic          ready = 1'b0;
    logic [53:0]   rnd = '0;
    logic          valid, busy, err, valid4, busy4, err4;
    logic [NW-1:0] nonce, nonce4;
    logic [31:0]   cnt, cnt4;

    int vectors = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    pow_nonce_gen #(.NONCE_TRITS(NT), .STRIDE(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_rnd_trits(rnd), .i_req(req), .i_ready(ready),
        .o_valid(valid), .o_nonce(nonce), .o_busy(busy), .o_nonce_cnt(cnt), .o_err(err)
    );

    pow_nonce_gen #(.NONCE_TRITS(NT), .STRIDE(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_rnd_trits(rnd), .i_req(req4), .i_ready(ready),
        .o_valid(valid4), .o_nonce(nonce4), .o_busy(busy4), .o_nonce_cnt(cnt4), .o_err(err4)
    );

    // Reference model: transaction-level view. A fill that started at edge E
    // captures word k at edge E + STRIDE*(k+1); the nonce is offered once all
    // words are in, and cleared from view by a handshake.
    int            stride [2] = '{1, 4};
    bit            m_fill [2];
    bit            m_valid[2];
    bit            m_err  [2];
    int            m_age  [2];
    logic [NW-1:0] m_nonce[2];
    logic [31:0]   m_cnt  [2];

    function automatic bit has_bad(input logic [53:0] w);
        for (int k = 0; k < 27; k++) if (w[2*k +: 2] == 2'b10) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [53:0] rand_word();
        logic [53:0] w;
        logic [1:0]  codes [3] = '{2'b00, 2'b01, 2'b11};
        for (int k = 0; k < 27; k++) w[2*k +: 2] = codes[$urandom_range(0, 2)];
        return w;
    endfunction

    task automatic model_edge(input int i, input bit r);
        if (rst) begin
            m_fill[i] = 0; m_valid[i] = 0; m_err[i] = 0; m_age[i] = 0;
            m_nonce[i] = '0; m_cnt[i] = '0;
        end else if (m_valid[i]) begin
            if (ready) begin
                m_cnt[i]   = m_cnt[i] + 32'd1;
                m_valid[i] = 0;
                if (r) begin m_fill[i] = 1; m_age[i] = 0; end
            end
        end else if (m_fill[i]) begin
            m_age[i]++;
            if (m_age[i] % stride[i] == 0) begin
                m_nonce[i][54*(m_age[i]/stride[i] - 1) +: 54] = rnd;
                if (CHK && has_bad(rnd)) m_err[i] = 1;
                if (m_age[i] == W * stride[i]) begin m_fill[i] = 0; m_valid[i] = 1; end
            end
        end else if (r) begin
            m_fill[i] = 1; m_age[i] = 0;
        end
    endtask

    // Advance one clock edge, update the model, then settle away from the edge.
    task automatic tick();
        @(posedge clk);
        model_edge(0, req);
        model_edge(1, req4);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; req = 0; req4 = 0; ready = 0;
        tick(); tick();
        vectors++;
        if ({valid, busy, err, cnt} !== 35'd0 || nonce !== '0) begin
            fails++;
            $display("FAIL reset_state: got v%0b b%0b e%0b cnt=%0h nonce=%0h, want all zero", valid, busy, err, cnt, nonce);
        end
        rst = 0;
        for (int t = 0; t < 10; t++) begin
            rnd = rand_word();
            tick();
            vectors++;
            if ({valid, busy, cnt} !== 34'd0 || nonce !== '0) begin
                fails++;
                $display("FAIL idle_quiet t=%0d: got v%0b b%0b cnt=%0h nonce=%0h, want all zero", t, valid, busy, cnt, nonce);
            end
        end
    endtask

    task automatic test_single();
        ready = 1; req = 1;
        tick();
        req = 0;
        for (int t = 1; t <= 3; t++) begin
            rnd = 54'(t);
            tick();
            vectors++;
            if (valid !== (t == 3) || busy !== (t != 3)) begin
                fails++;
                $display("FAIL single_latency edge=%0d: got v%0b b%0b, want v%0b b%0b", t, valid, busy, t == 3, t != 3);
            end
        end
        vectors++;
        if (nonce !== {54'h3, 54'h2, 54'h1} || err !== m_err[0]) begin
            fails++;
            $display("FAIL single_nonce: got %0h e%0b, want %0h e%0b", nonce, err, {54'h3, 54'h2, 54'h1}, m_err[0]);
        end
        tick();
        vectors++;
        if (valid !== 1'b0 || cnt !== 32'd1) begin
            fails++;
            $display("FAIL single_handshake: got v%0b cnt=%0d, want v0 cnt=1", valid, cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [NW-1:0] held;
        logic [31:0]   c0;
        bit            seen = 0;
        ready = 0; req = 1;
        tick();
        req = 0;
        for (int t = 0; t < 10 && !seen; t++) begin
            rnd = rand_word();
            tick();
            seen = valid;
        end
        vectors++;
        if (!seen || nonce !== m_nonce[0]) begin
            fails++;
            $display("FAIL bp_fill: got v%0b nonce=%0h, want v1 nonce=%0h", valid, nonce, m_nonce[0]);
        end
        held = m_nonce[0];
        c0   = m_cnt[0];
        for (int t = 0; t < 20; t++) begin
            rnd = rand_word();
            req = 1'($urandom_range(0, 1));
            tick();
            vectors++;
            if (valid !== 1'b1 || nonce !== held || cnt !== c0) begin
                fails++;
                $display("FAIL bp_hold t=%0d: got v%0b cnt=%0h nonce=%0h, want v1 cnt=%0h nonce=%0h", t, valid, cnt, nonce, c0, held);
            end
        end
        req = 0; ready = 1;
        tick();
        vectors++;
        if (valid !== 1'b0 || busy !== 1'b0 || cnt !== c0 + 32'd1) begin
            fails++;
            $display("FAIL bp_release: got v%0b b%0b cnt=%0h, want v0 b0 cnt=%0h", valid, busy, cnt, c0 + 32'd1);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] c0 = m_cnt[0];
        req = 1; ready = 1;
        for (int t = 1; t <= 21; t++) begin
            rnd = rand_word();
            tick();
            vectors++;
            if (valid !== (t % 4 == 0) || (busy | valid) !== 1'b1 || nonce !== m_nonce[0] || cnt !== m_cnt[0]) begin
                fails++;
                $display("FAIL b2b t=%0d: got v%0b b%0b cnt=%0h nonce=%0h, want v%0b cnt=%0h nonce=%0h",
                         t, valid, busy, cnt, nonce, t % 4 == 0, m_cnt[0], m_nonce[0]);
            end
        end
        vectors++;
        if (cnt !== c0 + 32'd5) begin
            fails++;
            $display("FAIL b2b_count: got %0d, want %0d", cnt, c0 + 32'd5);
        end
        req = 0;
        for (int t = 0; t < 8; t++) begin
            rnd = rand_word();
            tick();
            vectors++;
            if ({valid, busy, cnt} !== {m_valid[0], m_fill[0], m_cnt[0]} || nonce !== m_nonce[0]) begin
                fails++;
                $display("FAIL b2b_drain t=%0d: got v%0b b%0b cnt=%0h, want v%0b b%0b cnt=%0h",
                         t, valid, busy, cnt, m_valid[0], m_fill[0], m_cnt[0]);
            end
        end
    endtask

    task automatic test_stride4();
        logic [53:0] first = '0;
        ready = 0; req4 = 1;
        tick();
        req4 = 0;
        for (int t = 1; t <= 12; t++) begin
            rnd = rand_word();
            if (t == 4) first = rnd;
            tick();
            vectors++;
            if (valid4 !== (t == 12) || busy4 !== (t != 12) || nonce4 !== m_nonce[1]) begin
                fails++;
                $display("FAIL stride4 edge=%0d: got v%0b b%0b nonce=%0h, want v%0b b%0b nonce=%0h",
                         t, valid4, busy4, nonce4, t == 12, t != 12, m_nonce[1]);
            end
            if (t == 3 || t == 4) begin
                vectors++;
                if (nonce4[53:0] !== ((t == 4) ? first : 54'd0)) begin
                    fails++;
                    $display("FAIL stride4_first edge=%0d: got %0h, want %0h", t, nonce4[53:0], (t == 4) ? first : 54'd0);
                end
            end
        end
        ready = 1;
        tick();
        vectors++;
        if (valid4 !== 1'b0 || cnt4 !== 32'd1 || err4 !== m_err[1]) begin
            fails++;
            $display("FAIL stride4_handshake: got v%0b cnt=%0d e%0b, want v0 cnt=1 e%0b", valid4, cnt4, err4, m_err[1]);
        end
    endtask

    task automatic test_reset_midfill();
        ready = 0; req = 1;
        tick();
        req = 0; rnd = rand_word();
        tick();
        vectors++;
        if (nonce !== m_nonce[0] || busy !== 1'b1) begin
            fails++;
            $display("FAIL midfill_capture: got b%0b nonce=%0h, want b1 nonce=%0h", busy, nonce, m_nonce[0]);
        end
        rst = 1;
        tick();
        rst = 0;
        vectors++;
        if ({valid, busy, err, cnt} !== 35'd0 || nonce !== '0) begin
            fails++;
            $display("FAIL midfill_reset: got v%0b b%0b e%0b cnt=%0h nonce=%0h, want all zero", valid, busy, err, cnt, nonce);
        end
    endtask

    task automatic test_wrap();
        force dut.o_nonce_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.o_nonce_cnt;
        m_cnt[0] = 32'hFFFF_FFFF;
        ready = 0; req = 1;
        tick();
        req = 0;
        for (int t = 0; t < 3; t++) begin rnd = rand_word(); tick(); end
        vectors++;
        if (valid !== 1'b1 || cnt !== 32'hFFFF_FFFF || nonce !== m_nonce[0]) begin
            fails++;
            $display("FAIL wrap_pre: got v%0b cnt=%0h nonce=%0h, want v1 cnt=ffffffff nonce=%0h", valid, cnt, nonce, m_nonce[0]);
        end
        ready = 1;
        tick();
        vectors++;
        if (valid !== 1'b0 || cnt !== 32'd0) begin
            fails++;
            $display("FAIL wrap_count: got v%0b cnt=%0h, want v0 cnt=0", valid, cnt);
        end
    endtask

    task automatic test_err();
        logic [53:0] w;
        rst = 1; tick(); rst = 0;
        ready = 0; req = 1;
        tick();
        req = 0;
        w = rand_word();
        w[11:10] = 2'b10;
        rnd = w;
        tick();
        vectors++;
        if (err !== CHK || nonce[53:0] !== w) begin
            fails++;
            $display("FAIL err_set: got e%0b word0=%0h, want e%0b word0=%0h", err, nonce[53:0], CHK, w);
        end
        for (int t = 0; t < 4; t++) begin
            rnd = rand_word();
            ready = (t == 3);
            tick();
            vectors++;
            if (err !== CHK || err !== m_err[0] || valid !== m_valid[0]) begin
                fails++;
                $display("FAIL err_sticky t=%0d: got e%0b v%0b, want e%0b v%0b", t, err, valid, CHK, m_valid[0]);
            end
        end
        rst = 1; tick(); rst = 0;
        vectors++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL err_clear: got e%0b, want e0", err);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_fill[i] = 0; m_valid[i] = 0; m_err[i] = 0; m_age[i] = 0;
            m_nonce[i] = '0; m_cnt[i] = '0;
        end
        #2;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_stride4();
        test_reset_midfill();
        test_wrap();
        test_err();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
